// File: rtl/ped_crossing_controller.sv
// ped_crossing_controller
//   Pedestrian crossing controller that sits downstream of the intersection
//   light controller. It latches a push-button request for each direction.
//   On the green entry of the matching direction it grants a timed WALK
//   window, followed by a flashing CLEAR window. It also watches the light
//   bus for illegal or conflicting codes and blanks all walk lamps on a fault.
//
//   Build option: PED_FAULT_LATCH_EN
//     defined   -> fault is sticky until rst, and no new WALK is granted
//                  while fault is set.
//     undefined -> fault follows the registered fault condition.
//
//   Ports (top):
//     clk_i, rst_i            clock (rising edge), async active-high reset
//     ns_light_i, ew_light_i  one-hot light codes (RED=100 YELLOW=010 GREEN=001)
//     ped_req_ns_i/_ew_i      push buttons, level or pulse
//     ns_walk_o, ns_flash_o   N/S walk lamp and flashing don't-walk lamp
//     ew_walk_o, ew_flash_o   E/W walk lamp and flashing don't-walk lamp
//     ns_pending_o/_ew_       request latched but not yet served
//     fault_o                 illegal or conflicting light code seen
//     ns_state_o, ew_state_o  per-direction FSM state (0 IDLE, 1 ARMED,
//                             2 WALK, 3 CLEAR), for debug
//
//   Handshake: there is no valid/ready flow. Each button is sampled on
//   every rising clock edge, and a single high sample is enough to register
//   a request.

// ped_dir_fsm
//   Serves one crossing direction. It contains the IDLE/ARMED/WALK/CLEAR
//   FSM, the phase counter, the queued-request flag and the registered
//   green flag used to detect a green entry.
module ped_dir_fsm #(
    parameter int unsigned WALK_CYCLES = 2,
    parameter int unsigned CLR_CYCLES  = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] light_i,
    input  logic       req_i,
    input  logic       fault_cond_i, // current-cycle illegal light bus
    input  logic       grant_en_i,   // low blocks new WALK grants
    output logic       walk_o,
    output logic       flash_o,
    output logic       pending_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WALK  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             queued_q, queued_d;
    logic             green_prev_q;

    logic             green;
    logic             grant;
    logic [CNT_W-1:0] cnt_inc;

    assign green   = (light_i == 3'b001);
    assign grant   = green & ~green_prev_q & grant_en_i;
    // The counter saturates so that a wide CNT_W can never wrap.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        queued_d = queued_q;

        case (state_q)
            ST_IDLE: begin
                // A request that arrives in the same cycle as the green
                // entry is served immediately.
                if (req_i) begin
                    state_d = grant ? ST_WALK : ST_ARMED;
                    cnt_d   = '0;
                end
            end
            ST_ARMED: begin
                if (grant) begin
                    state_d = ST_WALK;
                    cnt_d   = '0;
                end
            end
            ST_WALK: begin
                if (req_i) queued_d = 1'b1;
                if (!green || cnt_q == WALK_LAST) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_CLEAR: begin
                if (req_i) queued_d = 1'b1;
                if (cnt_q == CLR_LAST) begin
                    state_d  = (queued_q || req_i) ? ST_ARMED : ST_IDLE;
                    queued_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A bad light bus interrupts any grant in progress. The request is
        // kept, so the direction falls back to ARMED, or to IDLE if no
        // request exists.
        if (fault_cond_i) begin
            state_d  = (state_q == ST_IDLE && !req_i) ? ST_IDLE : ST_ARMED;
            cnt_d    = '0;
            queued_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            queued_q     <= 1'b0;
            green_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            queued_q     <= queued_d;
            green_prev_q <= green;
        end
    end

    // These outputs are decoded only from flops.
    assign walk_o    = (state_q == ST_WALK);
    assign flash_o   = (state_q == ST_CLEAR);
    assign pending_o = (state_q == ST_ARMED) ||
                       (((state_q == ST_WALK) || (state_q == ST_CLEAR)) && queued_q);
    assign state_o   = state_q;

endmodule

module ped_crossing_controller #(
    parameter int unsigned WALK_CYCLES = 2,
    parameter int unsigned CLR_CYCLES  = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] ns_light_i,
    input  logic [2:0] ew_light_i,
    input  logic       ped_req_ns_i,
    input  logic       ped_req_ew_i,
    output logic       ns_walk_o,
    output logic       ns_flash_o,
    output logic       ew_walk_o,
    output logic       ew_flash_o,
    output logic       ns_pending_o,
    output logic       ew_pending_o,
    output logic       fault_o,
    output logic [1:0] ns_state_o,
    output logic [1:0] ew_state_o
);

    logic fault_cond;
    logic fault_q, fault_d;
    logic grant_en;
    logic ns_ok, ew_ok;

    assign ns_ok = (ns_light_i == 3'b001) || (ns_light_i == 3'b010) || (ns_light_i == 3'b100);
    assign ew_ok = (ew_light_i == 3'b001) || (ew_light_i == 3'b010) || (ew_light_i == 3'b100);

    // A fault is either light not being one-hot, or both directions being
    // away from RED in the same cycle.
    assign fault_cond = !ns_ok || !ew_ok ||
                        ((ns_light_i != 3'b100) && (ew_light_i != 3'b100));

`ifdef PED_FAULT_LATCH_EN
    assign fault_d  = fault_q | fault_cond;
    assign grant_en = ~fault_q;
`else
    assign fault_d  = fault_cond;
    assign grant_en = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;

    ped_dir_fsm #(
        .WALK_CYCLES (WALK_CYCLES),
        .CLR_CYCLES  (CLR_CYCLES),
        .CNT_W       (CNT_W)
    ) u_ns (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .light_i      (ns_light_i),
        .req_i        (ped_req_ns_i),
        .fault_cond_i (fault_cond),
        .grant_en_i   (grant_en),
        .walk_o       (ns_walk_o),
        .flash_o      (ns_flash_o),
        .pending_o    (ns_pending_o),
        .state_o      (ns_state_o)
    );

    ped_dir_fsm #(
        .WALK_CYCLES (WALK_CYCLES),
        .CLR_CYCLES  (CLR_CYCLES),
        .CNT_W       (CNT_W)
    ) u_ew (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .light_i      (ew_light_i),
        .req_i        (ped_req_ew_i),
        .fault_cond_i (fault_cond),
        .grant_en_i   (grant_en),
        .walk_o       (ew_walk_o),
        .flash_o      (ew_flash_o),
        .pending_o    (ew_pending_o),
        .state_o      (ew_state_o)
    );

endmodule

// File: tb/tb_ped_crossing_controller.sv
// Bench for ped_crossing_controller.
//   u_dut  : default parameters (WALK_CYCLES=2, CLR_CYCLES=1)
//   u_dut4 : WALK_CYCLES=4, used for the walk-abort sequence
// Output vectors are packed as {ns_walk, ns_flash, ew_walk, ew_flash,
// ns_pending, ew_pending, fault}.
module tb_ped_crossing_controller;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ns_light, ew_light;
    logic       req_ns, req_ew;

    logic       ns_walk, ns_flash, ew_walk, ew_flash, ns_pend, ew_pend, fault;
    logic [1:0] ns_st, ew_st;
    logic       ns_walk4, ns_flash4, ew_walk4, ew_flash4, ns_pend4, ew_pend4, fault4;
    logic [1:0] ns_st4, ew_st4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ped_crossing_controller u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ns_light_i   (ns_light),
        .ew_light_i   (ew_light),
        .ped_req_ns_i (req_ns),
        .ped_req_ew_i (req_ew),
        .ns_walk_o    (ns_walk),
        .ns_flash_o   (ns_flash),
        .ew_walk_o    (ew_walk),
        .ew_flash_o   (ew_flash),
        .ns_pending_o (ns_pend),
        .ew_pending_o (ew_pend),
        .fault_o      (fault),
        .ns_state_o   (ns_st),
        .ew_state_o   (ew_st)
    );

    ped_crossing_controller #(
        .WALK_CYCLES (4),
        .CLR_CYCLES  (1),
        .CNT_W       (4)
    ) u_dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .ns_light_i   (ns_light),
        .ew_light_i   (ew_light),
        .ped_req_ns_i (req_ns),
        .ped_req_ew_i (req_ew),
        .ns_walk_o    (ns_walk4),
        .ns_flash_o   (ns_flash4),
        .ew_walk_o    (ew_walk4),
        .ew_flash_o   (ew_flash4),
        .ns_pending_o (ns_pend4),
        .ew_pending_o (ew_pend4),
        .fault_o      (fault4),
        .ns_state_o   (ns_st4),
        .ew_state_o   (ew_st4)
    );

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       rn;
        logic       re;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [30];

    function automatic logic [6:0] obs();
        return {ns_walk, ns_flash, ew_walk, ew_flash, ns_pend, ew_pend, fault};
    endfunction

    function automatic logic [6:0] obs4();
        return {ns_walk4, ns_flash4, ew_walk4, ew_flash4, ns_pend4, ew_pend4, fault4};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive the inputs for one cycle, then sample just after the edge.
    task automatic step(input logic [2:0] ns, input logic [2:0] ew,
                        input logic rn, input logic re);
        ns_light = ns;
        ew_light = ew;
        req_ns   = rn;
        req_ew   = re;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ns_light = R;
        ew_light = R;
        req_ns   = 1'b0;
        req_ew   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ns_light = G;
        ew_light = R;
        req_ns   = 1'b0;
        req_ew   = 1'b0;

        // Normal operation: both directions, a mid-green request, a request
        // queued during WALK, and a request coincident with green entry.
        vecs[0]  = '{G, R, 1'b0, 1'b0, 7'b0000000};
        vecs[1]  = '{G, R, 1'b0, 1'b0, 7'b0000000};
        vecs[2]  = '{G, R, 1'b0, 1'b0, 7'b0000000};
        vecs[3]  = '{Y, R, 1'b1, 1'b0, 7'b0000100};
        vecs[4]  = '{Y, R, 1'b0, 1'b0, 7'b0000100};
        vecs[5]  = '{R, G, 1'b0, 1'b0, 7'b0000100};
        vecs[6]  = '{R, G, 1'b0, 1'b1, 7'b0000110};
        vecs[7]  = '{R, G, 1'b0, 1'b0, 7'b0000110};
        vecs[8]  = '{R, Y, 1'b0, 1'b0, 7'b0000110};
        vecs[9]  = '{R, Y, 1'b0, 1'b0, 7'b0000110};
        vecs[10] = '{G, R, 1'b0, 1'b0, 7'b1000010};
        vecs[11] = '{G, R, 1'b0, 1'b0, 7'b1000010};
        vecs[12] = '{G, R, 1'b0, 1'b0, 7'b0100010};
        vecs[13] = '{Y, R, 1'b0, 1'b0, 7'b0000010};
        vecs[14] = '{Y, R, 1'b0, 1'b0, 7'b0000010};
        vecs[15] = '{R, G, 1'b0, 1'b0, 7'b0010000};
        vecs[16] = '{R, G, 1'b0, 1'b1, 7'b0010010};
        vecs[17] = '{R, G, 1'b0, 1'b0, 7'b0001010};
        vecs[18] = '{R, Y, 1'b0, 1'b0, 7'b0000010};
        vecs[19] = '{R, Y, 1'b0, 1'b0, 7'b0000010};
        vecs[20] = '{G, R, 1'b0, 1'b0, 7'b0000010};
        vecs[21] = '{Y, R, 1'b0, 1'b0, 7'b0000010};
        vecs[22] = '{R, G, 1'b0, 1'b0, 7'b0010000};
        vecs[23] = '{R, G, 1'b0, 1'b0, 7'b0010000};
        vecs[24] = '{R, G, 1'b0, 1'b0, 7'b0001000};
        vecs[25] = '{R, Y, 1'b0, 1'b0, 7'b0000000};
        vecs[26] = '{G, R, 1'b1, 1'b0, 7'b1000000};
        vecs[27] = '{G, R, 1'b0, 1'b0, 7'b1000000};
        vecs[28] = '{G, R, 1'b0, 1'b0, 7'b0100000};
        vecs[29] = '{Y, R, 1'b0, 1'b0, 7'b0000000};

        // Reset state
        @(posedge clk);
        #1;
        check("reset_outputs", obs(), 7'b0000000);
        check("reset_outputs_w4", obs4(), 7'b0000000);
        check("reset_state", {5'b0, ns_st}, {5'b0, 2'd0});
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            step(vecs[i].ns, vecs[i].ew, vecs[i].rn, vecs[i].re);
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Walk aborted by yellow after one walk cycle (WALK_CYCLES=4)
        do_reset();
        step(R, R, 1'b0, 1'b1);
        check("abort_armed", obs4(), 7'b0000010);
        step(R, G, 1'b0, 1'b0);
        check("abort_walk", obs4(), 7'b0010000);
        step(R, Y, 1'b0, 1'b0);
        check("abort_flash", obs4(), 7'b0001000);
        step(R, Y, 1'b0, 1'b0);
        check("abort_idle", obs4(), 7'b0000000);

        // Illegal code during WALK, then a conflicting code
        do_reset();
        step(Y, R, 1'b1, 1'b0);
        check("fault_armed", obs(), 7'b0000100);
        step(G, R, 1'b0, 1'b0);
        check("fault_walk", obs(), 7'b1000000);
        step(3'b011, R, 1'b0, 1'b0);
        check("fault_hit", obs(), 7'b0000101);
`ifdef PED_FAULT_LATCH_EN
        step(G, R, 1'b0, 1'b0);
        check("fault_after1", obs(), 7'b0000101);
        step(G, R, 1'b0, 1'b0);
        check("fault_after2", obs(), 7'b0000101);
        step(G, G, 1'b0, 1'b0);
        check("fault_conflict", obs(), 7'b0000101);
        step(G, R, 1'b0, 1'b0);
        check("fault_sticky", obs(), 7'b0000101);
`else
        step(G, R, 1'b0, 1'b0);
        check("fault_after1", obs(), 7'b1000000);
        step(G, R, 1'b0, 1'b0);
        check("fault_after2", obs(), 7'b1000000);
        step(G, G, 1'b0, 1'b0);
        check("fault_conflict", obs(), 7'b0000101);
        step(G, R, 1'b0, 1'b0);
        check("fault_clear", obs(), 7'b0000100);
        step(R, R, 1'b0, 1'b0);
        check("fault_armed_hold", obs(), 7'b0000100);
`endif

        // Asynchronous reset mid-CLEAR with both requests pending
        do_reset();
        step(Y, R, 1'b1, 1'b1);
        check("rst_setup_armed", obs(), 7'b0000110);
        step(G, R, 1'b0, 1'b0);
        check("rst_setup_walk", obs(), 7'b1000010);
        step(G, R, 1'b1, 1'b0);
        check("rst_setup_queue", obs(), 7'b1000110);
        step(G, R, 1'b0, 1'b0);
        check("rst_setup_clear", obs(), 7'b0100110);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_drop", obs(), 7'b0000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            case (i % 10)
                0, 1, 2: step(G, R, 1'b0, 1'b0);
                3, 4:    step(Y, R, 1'b0, 1'b0);
                5, 6, 7: step(R, G, 1'b0, 1'b0);
                default: step(R, Y, 1'b0, 1'b0);
            endcase
            check($sformatf("rst_after%0d", i), obs(), 7'b0000000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
